// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// alu_pkg: ALU opcodes, capture count and arbiter state encoding.
// Revision: 1.0
// ------------------------------------------------------------------
package alu_pkg;
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_MUL = 2'd2;
   localparam logic [1:0] ALU_SHL = 2'd3;

   // Result lands one edge after the operands, zero flag one edge later.
   localparam logic [1:0] ALU_CAPTURE_CNT = 2'd2;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;
endpackage
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter2.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// rr_arbiter2: combinational two-way round-robin grant.
// Revision: 1.0
// ------------------------------------------------------------------
module rr_arbiter2
   import alu_pkg::*;
(
   input  logic [1:0] req_valid_i,
   input  logic       last_i,
   output logic [1:0] grant_o
);

   // On contention the requester that did not win last time gets the grant.
   always_comb begin
      grant_o = 2'b00;
      case (req_valid_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11:   grant_o = last_i ? 2'b01 : 2'b10;
         default: grant_o = 2'b00;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// alu_arbiter: shares one registered-output ALU between two requesters.
// Revision: 1.0
// ------------------------------------------------------------------
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [1:0]   req_valid_i,
   output logic [1:0]   req_ready_o,
   input  logic [1:0]   req_op0_i,
   input  logic [N-1:0] req_a0_i,
   input  logic [N-1:0] req_b0_i,
   input  logic [1:0]   req_op1_i,
   input  logic [N-1:0] req_a1_i,
   input  logic [N-1:0] req_b1_i,
   output logic [N-1:0] alu_in1_o,
   output logic [N-1:0] alu_in2_o,
   output logic [1:0]   alu_op_o,
   input  logic [N-1:0] alu_out_i,
   input  logic         alu_z_i,
   output logic         resp_valid_o,
   input  logic         resp_ready_i,
   output logic [N-1:0] resp_data_o,
   output logic         resp_zero_o,
   output logic         resp_id_o,
   output logic         busy_o
);

   logic [1:0]   state_q, state_d;
   logic [1:0]   cnt_q;
   logic         last_q;
   logic         id_q;
   logic [N-1:0] in1_q, in2_q;
   logic [1:0]   op_q;
   logic [N-1:0] resp_data_q;
   logic         resp_zero_q;
   logic         resp_valid_q;

   logic [1:0]   grant;
   logic         accept;
   logic         sel;
   logic         capture;

   rr_arbiter2 u_rr (
      .req_valid_i (req_valid_i),
      .last_i      (last_q),
      .grant_o     (grant)
   );

   assign accept  = |(req_valid_i & req_ready_o);
   assign sel     = grant[1];
   assign capture = (state_q == EXEC) && (cnt_q == ALU_CAPTURE_CNT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)       state_d = EXEC;
         EXEC:    if (capture)      state_d = RESP;
         RESP:    if (resp_ready_i) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready_o = (state_q == IDLE) ? grant : 2'b00;
      busy_o      = (state_q != IDLE);
   end

   // Operands stay frozen from accept until the next accept, so the ALU
   // sees stable inputs for the whole result/zero-flag pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q        <= 2'd0;
         last_q       <= 1'b1;
         id_q         <= 1'b0;
         in1_q        <= '0;
         in2_q        <= '0;
         op_q         <= 2'd0;
         resp_data_q  <= '0;
         resp_zero_q  <= 1'b0;
         resp_valid_q <= 1'b0;
      end else begin
         if (accept) begin
            in1_q  <= sel ? req_a1_i  : req_a0_i;
            in2_q  <= sel ? req_b1_i  : req_b0_i;
            op_q   <= sel ? req_op1_i : req_op0_i;
            id_q   <= sel;
            last_q <= sel;
            cnt_q  <= 2'd0;
         end
         if (state_q == EXEC) begin
            cnt_q <= cnt_q + 2'd1;
         end
         if (capture) begin
            resp_data_q  <= alu_out_i;
            resp_zero_q  <= alu_z_i;
            resp_valid_q <= 1'b1;
         end
         if ((state_q == RESP) && resp_ready_i) begin
            resp_valid_q <= 1'b0;
         end
      end
   end

   assign alu_in1_o    = in1_q;
   assign alu_in2_o    = in2_q;
   assign alu_op_o     = op_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_zero_o  = resp_zero_q;
   assign resp_id_o    = id_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_alu_arbiter: directed vectors, corner sequences and random traffic.
// Revision: 1.0
// ------------------------------------------------------------------
module tb_alu_arbiter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] req_valid = 2'b00;
   logic [1:0] req_ready;
   logic [1:0] req_op0 = 2'd0, req_op1 = 2'd0;
   logic [7:0] req_a0 = 8'd0, req_b0 = 8'd0, req_a1 = 8'd0, req_b1 = 8'd0;
   logic [7:0] alu_in1, alu_in2;
   logic [1:0] alu_op;
   logic [7:0] alu_out;
   logic       alu_z;
   logic       resp_valid;
   logic       resp_ready = 1'b1;
   logic [7:0] resp_data;
   logic       resp_zero;
   logic       resp_id;
   logic       busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_arbiter #(.N(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_ready_o  (req_ready),
      .req_op0_i    (req_op0),
      .req_a0_i     (req_a0),
      .req_b0_i     (req_b0),
      .req_op1_i    (req_op1),
      .req_a1_i     (req_a1),
      .req_b1_i     (req_b1),
      .alu_in1_o    (alu_in1),
      .alu_in2_o    (alu_in2),
      .alu_op_o     (alu_op),
      .alu_out_i    (alu_out),
      .alu_z_i      (alu_z),
      .resp_valid_o (resp_valid),
      .resp_ready_i (resp_ready),
      .resp_data_o  (resp_data),
      .resp_zero_o  (resp_zero),
      .resp_id_o    (resp_id),
      .busy_o       (busy)
   );

   function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                          input logic [7:0] b);
      int ia, ib, r;
      ia = int'(a);
      ib = int'(b);
      case (op)
         2'd0:    r = (ia + ib) % 256;
         2'd1:    r = (ia - ib + 256) % 256;
         2'd2:    r = (ia * ib) % 256;
         default: r = (ib >= 8) ? 0 : (ia * (1 << ib)) % 256;
      endcase
      return r[7:0];
   endfunction

   // ALU instance model: result one edge after operands, zero flag one edge after result.
   always @(posedge clk) begin
      if (rst) begin
         alu_out <= 8'd0;
         alu_z   <= 1'b0;
      end else begin
         alu_out <= alu_ref(alu_op, alu_in1, alu_in2);
         alu_z   <= (alu_out == 8'd0);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit id, input logic [1:0] op, input logic [7:0] a,
                          input logic [7:0] b);
      if (id == 1'b0) begin
         req_op0 = op; req_a0 = a; req_b0 = b;
      end else begin
         req_op1 = op; req_a1 = a; req_b1 = b;
      end
   endtask

   // Returns with resp_valid seen; consumes it only when resp_ready is high.
   task automatic issue(input bit id, input logic [1:0] op, input logic [7:0] a,
                        input logic [7:0] b, output logic [7:0] d, output logic z,
                        output logic rid, output int lat);
      int w;
      set_req(id, op, a, b);
      req_valid[id] = 1'b1;
      w = 0;
      #1;
      while (!req_ready[id] && w < 20) begin
         step(); #1; w++;
      end
      check("accept_wait", int'(w < 20), 1);
      step();
      req_valid[id] = 1'b0;
      lat = 0;
      #1;
      while (!resp_valid && lat < 10) begin
         step(); #1; lat++;
      end
      d   = resp_data;
      z   = resp_zero;
      rid = resp_id;
      if (resp_ready) step();
   endtask

   typedef struct {
      bit         id;
      logic [1:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       z;
   } vec_t;

   typedef struct {
      bit         id;
      logic [7:0] d;
      logic       z;
      int         it;
   } exp_t;

   initial begin
      vec_t       vt[10];
      exp_t       exq[$];
      exp_t       e;
      logic [7:0] d;
      logic       z, rid;
      int         lat, n, w;
      int         acc_it[8];
      int         acc_w[8];
      bit         pend[2];
      logic [1:0] pop[2];
      logic [7:0] pa[2], pb[2];
      logic [1:0] acc;
      int         prev_w, exp_w, nresp;
      bit         seen;

      vt[0] = '{1'b0, 2'd0, 8'd5,    8'd3,   8'd8,    1'b0};
      vt[1] = '{1'b1, 2'd1, 8'd7,    8'd7,   8'd0,    1'b1};
      vt[2] = '{1'b0, 2'd2, 8'd16,   8'd16,  8'd0,    1'b1};
      vt[3] = '{1'b1, 2'd3, 8'd1,    8'd3,   8'd8,    1'b0};
      vt[4] = '{1'b0, 2'd0, 8'd200,  8'd100, 8'd44,   1'b0};
      vt[5] = '{1'b1, 2'd1, 8'd3,    8'd5,   8'd254,  1'b0};
      vt[6] = '{1'b0, 2'd2, 8'd15,   8'd17,  8'd255,  1'b0};
      vt[7] = '{1'b1, 2'd3, 8'd1,    8'd8,   8'd0,    1'b1};
      vt[8] = '{1'b0, 2'd3, 8'h81,   8'd1,   8'h02,   1'b0};
      vt[9] = '{1'b1, 2'd0, 8'd255,  8'd1,   8'd0,    1'b1};

      // Reset with both requesters asking, then both held: grants must alternate.
      rst = 1'b1;
      req_valid = 2'b11;
      set_req(1'b0, 2'd0, 8'd5, 8'd3);
      set_req(1'b1, 2'd1, 8'd7, 8'd7);
      step(); step(); #1;
      check("rst_resp_valid", int'(resp_valid), 0);
      check("rst_resp_data",  int'(resp_data), 0);
      check("rst_resp_zero",  int'(resp_zero), 0);
      check("rst_resp_id",    int'(resp_id), 0);
      check("rst_alu_in1",    int'(alu_in1), 0);
      check("rst_alu_in2",    int'(alu_in2), 0);
      check("rst_alu_op",     int'(alu_op), 0);
      check("rst_busy",       int'(busy), 0);
      rst = 1'b0;
      #1;
      check("first_grant", int'(req_ready), 1);
      n = 0;
      for (int it = 0; it < 22; it++) begin
         if (req_ready != 2'b00 && n < 8) begin
            acc_it[n] = it;
            acc_w[n]  = int'(req_ready[1]);
            n++;
         end
         if (resp_valid) begin
            check("alt_resp_id",   int'(resp_id), acc_w[n-1]);
            check("alt_resp_data", int'(resp_data), acc_w[n-1] == 0 ? 8 : 0);
            check("alt_resp_zero", int'(resp_zero), acc_w[n-1] == 0 ? 0 : 1);
         end
         step(); #1;
      end
      check("alt_count", int'(n >= 4), 1);
      for (int j = 0; j < 4; j++) begin
         check("alt_cycle",  acc_it[j], 5 * j);
         check("alt_winner", acc_w[j], j % 2);
      end
      req_valid = 2'b00;
      w = 0;
      while (busy && w < 20) begin
         step(); #1; w++;
      end
      check("drain_busy", int'(busy), 0);

      // Directed vectors through both requesters.
      for (int i = 0; i < 10; i++) begin
         issue(vt[i].id, vt[i].op, vt[i].a, vt[i].b, d, z, rid, lat);
         check("vec_data", int'(d), int'(vt[i].d));
         check("vec_zero", int'(z), int'(vt[i].z));
         check("vec_id",   int'(rid), int'(vt[i].id));
         check("vec_lat",  lat, 3);
      end

      // Response back-pressure: resp_* held, no new accept while stalled.
      resp_ready = 1'b0;
      issue(1'b0, 2'd2, 8'd16, 8'd16, d, z, rid, lat);
      check("stall_lat", lat, 3);
      set_req(1'b0, 2'd3, 8'd1, 8'd3);
      req_valid[0] = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("stall_valid", int'(resp_valid), 1);
         check("stall_data",  int'(resp_data), 0);
         check("stall_zero",  int'(resp_zero), 1);
         check("stall_ready", int'(req_ready), 0);
         step();
      end
      resp_ready = 1'b1;
      step(); #1;
      check("stall_release", int'(resp_valid), 0);
      issue(1'b0, 2'd3, 8'd1, 8'd3, d, z, rid, lat);
      check("shl_data", int'(d), 8);
      check("shl_zero", int'(z), 0);
      check("shl_lat",  lat, 3);

      // Reset while executing with cnt==1 must drop the in-flight op.
      set_req(1'b1, 2'd0, 8'd10, 8'd20);
      req_valid[1] = 1'b1;
      w = 0;
      #1;
      while (!req_ready[1] && w < 20) begin
         step(); #1; w++;
      end
      check("abort_accept", int'(req_ready[1]), 1);
      step();
      req_valid[1] = 1'b0;
      step();
      check("abort_busy_before", int'(busy), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("abort_no_resp", int'(resp_valid), 0);
         check("abort_idle",    int'(busy), 0);
         step();
      end
      issue(1'b0, 2'd1, 8'd3, 8'd5, d, z, rid, lat);
      check("after_abort_data", int'(d), 254);
      check("after_abort_zero", int'(z), 0);
      check("after_abort_id",   int'(rid), 0);
      check("after_abort_lat",  lat, 3);

      // Random traffic against a transaction-level model.
      rst = 1'b1;
      req_valid = 2'b00;
      step(); step();
      rst = 1'b0;
      pend[0] = 1'b0; pend[1] = 1'b0;
      prev_w = 1;
      nresp  = 0;
      seen   = 1'b0;
      for (int it = 0; it < 1500; it++) begin
         for (int k = 0; k < 2; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k] = 1'b1;
               pop[k]  = 2'($urandom_range(0, 3));
               pa[k]   = 8'($urandom_range(0, 255));
               pb[k]   = (pop[k] == 2'd3) ? 8'($urandom_range(0, 10))
                                          : 8'($urandom_range(0, 255));
            end
         end
         set_req(1'b0, pop[0], pa[0], pb[0]);
         set_req(1'b1, pop[1], pa[1], pb[1]);
         req_valid  = {pend[1], pend[0]};
         resp_ready = ($urandom_range(0, 2) != 0);
         #1;
         acc = req_valid & req_ready;
         check("rand_accept_expected", int'(acc != 2'b00),
               int'(exq.size() == 0 && (pend[0] || pend[1])));
         if (acc != 2'b00) begin
            exp_w = (pend[0] && pend[1]) ? 1 - prev_w : (pend[0] ? 0 : 1);
            check("rand_grant", int'(acc), 1 << exp_w);
            e.id = acc[1];
            e.d  = alu_ref(pop[int'(acc[1])], pa[int'(acc[1])], pb[int'(acc[1])]);
            e.z  = (e.d == 8'd0);
            e.it = it;
            exq.push_back(e);
            prev_w = int'(acc[1]);
            pend[int'(acc[1])] = 1'b0;
         end
         if (resp_valid) begin
            if (exq.size() == 0) begin
               check("rand_spurious_resp", 1, 0);
            end else begin
               if (!seen) begin
                  check("rand_latency", it, exq[0].it + 4);
                  seen = 1'b1;
               end
               check("rand_data", int'(resp_data), int'(exq[0].d));
               check("rand_zero", int'(resp_zero), int'(exq[0].z));
               check("rand_id",   int'(resp_id), int'(exq[0].id));
               if (resp_ready) begin
                  void'(exq.pop_front());
                  seen = 1'b0;
                  nresp++;
               end
            end
         end else if (exq.size() != 0 && it > exq[0].it + 4) begin
            check("rand_resp_missing", 0, 1);
         end
         step();
      end
      check("rand_resp_count", int'(nresp > 50), 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
